// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared constants, payload type and segment patterns for the seven-segment scan controller.
package sseg_scan_ctrl_pkg;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned HEX_W  = 4 * DIGITS;

  localparam logic [7:0]        SSEG_BLANK = 8'hFF;
  localparam logic [DIGITS-1:0] AN_OFF     = 4'b1111;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef struct packed {
    logic [HEX_W-1:0]  hex;
    logic [DIGITS-1:0] dp;
    logic [DIGITS-1:0] en;
  } disp_t;

endpackage

// File: rtl/sseg_scan_ctrl_hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment {g..a} decoder.
module hex_to_sseg
  import sseg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_0;
    case (nib)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      default: seg_c = SEG_F;
    endcase
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-boundary (tear-free) updates.
// Optional build macro LZ_BLANK_EN enables leading-zero blanking of digits 3..1.
module sseg_scan_ctrl
  import sseg_scan_ctrl_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk_amisha,
  input  logic        reset_amisha,
  input  logic        load_amisha,
  input  logic [15:0] hex_amisha,
  input  logic [3:0]  dp_amisha,
  input  logic [3:0]  en_amisha,
  output logic        upd_done_amisha,
  output logic [3:0]  an_amisha,
  output logic [7:0]  sseg_amisha
);

  logic [CNT_W-1:0] presc;
  logic [1:0]       idx;
  logic             pend_valid;
  disp_t            pend;
  disp_t            act;
  disp_t            din;
  logic             tick;
  logic             frame_end;
  logic [3:0]       nib;
  logic [6:0]       seg7;
  logic             lz_dark;
  logic             dark;

  assign din       = '{hex: hex_amisha, dp: dp_amisha, en: en_amisha};
  assign tick      = (presc == CNT_W'(REFRESH_DIV - 1));
  assign frame_end = tick && (idx == 2'd3);
  assign nib       = act.hex[{idx, 2'b00} +: 4];

  hex_to_sseg u_dec (
    .nib   (nib),
    .seg_c (seg7)
  );

  // A digit is dark when its higher nibbles and its own are all zero and its dp is off
  always_comb begin
    lz_dark = 1'b0;
`ifdef LZ_BLANK_EN
    case (idx)
      2'd3:    lz_dark = (act.hex[15:12] == 4'h0) && !act.dp[3];
      2'd2:    lz_dark = (act.hex[15:8]  == 8'h00) && !act.dp[2];
      2'd1:    lz_dark = (act.hex[15:4]  == 12'h000) && !act.dp[1];
      default: lz_dark = 1'b0;
    endcase
`endif
  end

  assign dark = !act.en[idx] || lz_dark;

  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      presc           <= '0;
      idx             <= 2'd0;
      pend_valid      <= 1'b0;
      pend            <= '{hex: 16'h0000, dp: 4'h0, en: 4'hF};
      act             <= '{hex: 16'h0000, dp: 4'h0, en: 4'hF};
      upd_done_amisha <= 1'b0;
      an_amisha       <= AN_OFF;
      sseg_amisha     <= SSEG_BLANK;
    end else begin
      presc <= tick ? '0 : presc + CNT_W'(1);
      if (tick) idx <= idx + 2'd1;

      an_amisha   <= dark ? AN_OFF : ~(4'b0001 << idx);
      sseg_amisha <= dark ? SSEG_BLANK : {~act.dp[idx], seg7};

      // Commit only at frame end; a same-cycle load bypasses the pending register
      upd_done_amisha <= 1'b0;
      if (frame_end && load_amisha) begin
        act             <= din;
        pend_valid      <= 1'b0;
        upd_done_amisha <= 1'b1;
      end else if (frame_end && pend_valid) begin
        act             <= pend;
        pend_valid      <= 1'b0;
        upd_done_amisha <= 1'b1;
      end else if (load_amisha) begin
        pend       <= din;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl: behavioural model, directed scenarios, random traffic.
module tb_sseg_scan_ctrl;

  localparam int unsigned DIV = 4;
`ifdef LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] hex = 16'h0;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  en = 4'hF;
  logic        upd_done;
  logic [3:0]  an;
  logic [7:0]  sseg;

  int unsigned checks = 0;
  int unsigned errors = 0;

  sseg_scan_ctrl #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clk_amisha      (clk),
    .reset_amisha    (reset),
    .load_amisha     (load),
    .hex_amisha      (hex),
    .dp_amisha       (dp),
    .en_amisha       (en),
    .upd_done_amisha (upd_done),
    .an_amisha       (an),
    .sseg_amisha     (sseg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Behavioural model: time since reset decides the slot, frames are 4*DIV cycles
  int unsigned mcyc = 0;
  bit          armed = 1'b0;
  logic [15:0] a_hex, p_hex;
  logic [3:0]  a_dp, a_en, p_dp, p_en;
  bit          pv;
  logic [3:0]  exp_an;
  logic [7:0]  exp_sseg;
  logic        exp_upd;

  always @(posedge clk) begin
    int unsigned slot;
    bit fe, dk;
    if (reset) begin
      mcyc = 0; armed = 1'b1; pv = 1'b0;
      a_hex = 16'h0; a_dp = 4'h0; a_en = 4'hF;
      p_hex = 16'h0; p_dp = 4'h0; p_en = 4'hF;
      exp_an = 4'hF; exp_sseg = 8'hFF; exp_upd = 1'b0;
    end else begin
      slot = (mcyc / DIV) % 4;
      fe   = (mcyc % (4 * DIV)) == (4 * DIV - 1);
      dk   = !a_en[slot] ||
             (LZ && slot > 0 && (a_hex >> (4 * slot)) == 0 && !a_dp[slot]);
      exp_an   = dk ? 4'hF : 4'hF ^ 4'(1 << slot);
      exp_sseg = dk ? 8'hFF : {~a_dp[slot], seg_of(4'((a_hex >> (4 * slot)) & 16'hF))};
      exp_upd  = fe && (load || pv);
      if (fe && load) begin
        a_hex = hex; a_dp = dp; a_en = en; pv = 1'b0;
      end else if (fe && pv) begin
        a_hex = p_hex; a_dp = p_dp; a_en = p_en; pv = 1'b0;
      end else if (load) begin
        p_hex = hex; p_dp = dp; p_en = en; pv = 1'b1;
      end
      mcyc++;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (armed) begin
      checks += 3;
      if (an !== exp_an) begin
        errors++; $display("FAIL model_an t=%0t got=%b want=%b", $time, an, exp_an);
      end
      if (sseg !== exp_sseg) begin
        errors++; $display("FAIL model_sseg t=%0t got=%h want=%h", $time, sseg, exp_sseg);
      end
      if (upd_done !== exp_upd) begin
        errors++; $display("FAIL model_upd t=%0t got=%b want=%b", $time, upd_done, exp_upd);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic run_to(input int unsigned n);
    int unsigned guard = 0;
    while (mcyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (mcyc < n) chk("run_to_timeout", 8'(mcyc), 8'(n));
  endtask

  task automatic set_in(input logic l, input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
    load = l; hex = h; dp = d; en = e;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_an", 8'(an), 8'hF);
    chk("reset_sseg", sseg, 8'hFF);
    chk("reset_upd", 8'(upd_done), 8'h0);
    reset = 1'b0;

    // Scan rotation after reset
    run_to(1);  chk("t1_an0", 8'(an), 8'h0E); chk("t1_sseg0", sseg, 8'hC0);
    run_to(5);  chk("t1_an1", 8'(an), LZ ? 8'h0F : 8'h0D);

    // Mid-frame load waits for frame end
    set_in(1'b1, 16'h1234, 4'h0, 4'hF); run_to(6); set_in(1'b0, 16'h0, 4'h0, 4'hF);
    run_to(16); chk("t2_upd", 8'(upd_done), 8'h1); chk("t2_old", sseg, LZ ? 8'hFF : 8'hC0);
    run_to(17); chk("t2_d0", sseg, 8'h99); chk("t2_upd_low", 8'(upd_done), 8'h0);
    run_to(21); chk("t2_d1", sseg, 8'hB0);
    run_to(25); chk("t2_d2", sseg, 8'hA4);
    run_to(29); chk("t2_d3", sseg, 8'hF9); chk("t2_an3", 8'(an), 8'h07);

    // Last write wins
    set_in(1'b1, 16'hAAAA, 4'h0, 4'hF); run_to(30);
    set_in(1'b1, 16'h00F5, 4'h0, 4'hF); run_to(31); set_in(1'b0, 16'h0, 4'h0, 4'hF);
    run_to(32); chk("t3_upd", 8'(upd_done), 8'h1);
    run_to(33); chk("t3_d0", sseg, 8'h92);

    // Load on the frame_end cycle bypasses pending
    run_to(47); set_in(1'b1, 16'h8888, 4'h0, 4'hF); run_to(48); set_in(1'b0, 16'h0, 4'h0, 4'hF);
    chk("t4_upd", 8'(upd_done), 8'h1);
    run_to(49); chk("t4_d0", sseg, 8'h80);

    // Disabled digits and decimal point
    set_in(1'b1, 16'hFFFF, 4'h1, 4'h5); run_to(50); set_in(1'b0, 16'h0, 4'h0, 4'hF);
    run_to(65); chk("t5_an0", 8'(an), 8'h0E); chk("t5_sseg0", sseg, 8'h0E);
    run_to(69); chk("t5_an1", 8'(an), 8'h0F); chk("t5_sseg1", sseg, 8'hFF);

    // Reset mid-frame drops a pending load
    run_to(70); set_in(1'b1, 16'h1111, 4'h0, 4'hF); run_to(71); set_in(1'b0, 16'h0, 4'h0, 4'hF);
    reset = 1'b1; @(negedge clk);
    chk("t5_rst_an", 8'(an), 8'hF); chk("t5_rst_sseg", sseg, 8'hFF);
    reset = 1'b0;
    run_to(16); chk("t5_no_upd", 8'(upd_done), 8'h0);
    run_to(17); chk("t5_d0_zero", sseg, 8'hC0);

    // Leading zeros
    set_in(1'b1, 16'h0070, 4'h0, 4'hF); run_to(18); set_in(1'b0, 16'h0, 4'h0, 4'hF);
    run_to(33); chk("t6_d0", sseg, 8'hC0);
    run_to(37); chk("t6_d1", sseg, 8'hF8);
    run_to(41); chk("t6_d2", sseg, LZ ? 8'hFF : 8'hC0);
    run_to(45); chk("t6_d3", sseg, LZ ? 8'hFF : 8'hC0); chk("t6_an3", 8'(an), LZ ? 8'h0F : 8'h07);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 5) == 0);
      hex   = 16'($urandom);
      if ($urandom_range(0, 2) == 0) hex = hex & 16'h00FF;
      dp    = 4'($urandom);
      en    = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
